// File: rtl/store_size_handler.sv
// Store path for sw/sh/sb into word-addressed memory; sub-word stores do a
// read-modify-write of the aligned word, word stores write straight through.
module store_size_handler #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

  typedef struct packed {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  req_t          req, cur;
  logic [31:0]   aligned;
  logic [31:0]   addr_n, wdata_n;
  logic          rd_n, wr_n, err_n;

  // Little-endian lane merge of the store data into the word read back.
  function automatic logic [31:0] merge(input req_t r, input logic [31:0] rd);
    logic [31:0] w;
    w = rd;
    if (r.size == 2'b01) begin
      if (r.addr[1]) w[31:16] = r.wdata[15:0];
      else           w[15:0]  = r.wdata[15:0];
    end else begin
      case (r.addr[1:0])
        2'd0:    w[7:0]   = r.wdata[7:0];
        2'd1:    w[15:8]  = r.wdata[7:0];
        2'd2:    w[23:16] = r.wdata[7:0];
        default: w[31:24] = r.wdata[7:0];
      endcase
    end
    return w;
  endfunction

  // In IDLE the request is taken from the ports; afterwards only the latched copy counts.
  assign cur     = (state == IDLE) ? {size, addr, wdata} : req;
  assign aligned = {cur.addr[31:2], 2'b00};

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rd_n    = 1'b0;
    wr_n    = 1'b0;
    err_n   = 1'b0;
    addr_n  = '0;
    wdata_n = '0;
    case (state)
      IDLE: if (start) begin
        if (size == 2'b00) begin
          state_n = WRITE;
          wr_n    = 1'b1;
          addr_n  = aligned;
          wdata_n = wdata;
        end else if (size == 2'b11 || (size == 2'b01 && addr[0])) begin
          state_n = DONE;
          err_n   = 1'b1;
        end else begin
          state_n = READ;
          rd_n    = 1'b1;
          addr_n  = aligned;
        end
      end
      READ: begin
        state_n = WAIT;
        cnt_n   = CW'(MEM_LAT - 1);
        addr_n  = aligned;
      end
      WAIT: begin
        addr_n = aligned;
        if (cnt == '0) begin
          state_n = WRITE;
          wr_n    = 1'b1;
          wdata_n = merge(req, mem_rdata);
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      WRITE:   state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      req       <= '0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      if (state == IDLE && start) req <= cur;
      mem_addr  <= addr_n;
      mem_rd    <= rd_n;
      mem_wr    <= wr_n;
      mem_wdata <= wdata_n;
      busy      <= (state_n != IDLE);
      done      <= (state_n == DONE);
      err       <= err_n;
    end
  end

endmodule

// File: tb/tb_store_size_handler.sv
// Directed bench: table of single stores on a MEM_LAT=1 instance, plus
// hand-written corner sequences on MEM_LAT=1 and MEM_LAT=3 instances.
module tb_store_size_handler;

  logic        clk = 1'b0;
  logic        reset;
  logic        st1, st3;
  logic [1:0]  size_i;
  logic [31:0] addr_i, wdata_i, mem_word;
  logic [31:0] rdata1, rdata3, addr1, addr3, wd1, wd3;
  logic        rd1, wr1, busy1, done1, err1;
  logic        rd3, wr3, busy3, done3, err3;
  logic        rdv1;
  logic [2:0]  rdp3;
  logic        sel_v;
  logic        v_rd, v_wr, v_done, v_err;
  logic [31:0] v_addr, v_wdata;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  store_size_handler #(.MEM_LAT(1)) u1 (
    .clk(clk), .reset(reset), .start(st1), .size(size_i), .addr(addr_i), .wdata(wdata_i),
    .mem_rdata(rdata1), .mem_addr(addr1), .mem_rd(rd1), .mem_wr(wr1), .mem_wdata(wd1),
    .busy(busy1), .done(done1), .err(err1));

  store_size_handler #(.MEM_LAT(3)) u3 (
    .clk(clk), .reset(reset), .start(st3), .size(size_i), .addr(addr_i), .wdata(wdata_i),
    .mem_rdata(rdata3), .mem_addr(addr3), .mem_rd(rd3), .mem_wr(wr3), .mem_wdata(wd3),
    .busy(busy3), .done(done3), .err(err3));

  // Memory model: data is valid only MEM_LAT cycles after the read strobe, garbage otherwise.
  always @(posedge clk) begin
    rdv1 <= rd1;
    rdp3 <= {rdp3[1:0], rd3};
  end
  assign rdata1 = rdv1    ? mem_word : 32'hBAD0_BAD0;
  assign rdata3 = rdp3[2] ? mem_word : 32'hBAD0_BAD0;

  assign v_rd    = sel_v ? rd3   : rd1;
  assign v_wr    = sel_v ? wr3   : wr1;
  assign v_done  = sel_v ? done3 : done1;
  assign v_err   = sel_v ? err3  : err1;
  assign v_addr  = sel_v ? addr3 : addr1;
  assign v_wdata = sel_v ? wd3   : wd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one store and observe a fixed window; hold keeps start high until done
  // and scrambles the inputs right after acceptance.
  task automatic run_store(input bit sel, input logic [1:0] s, input logic [31:0] a,
                           input logic [31:0] w, input bit hold,
                           output int lat, output int ndone, output int nrd, output int nwr,
                           output int ovl, output logic [31:0] wd, output logic [31:0] wa,
                           output logic errv);
    lat = 0; ndone = 0; nrd = 0; nwr = 0; ovl = 0; wd = '0; wa = '0; errv = 1'b0;
    sel_v = sel;
    @(negedge clk);
    size_i = s; addr_i = a; wdata_i = w;
    if (sel) st3 = 1'b1; else st1 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (!hold) begin st1 = 1'b0; st3 = 1'b0; end
      if (hold && c == 1) begin size_i = 2'b00; addr_i = 32'h40; wdata_i = 32'h55; end
      if (v_done) begin
        ndone++;
        if (lat == 0) begin lat = c; errv = v_err; end
        if (hold) begin st1 = 1'b0; st3 = 1'b0; end
      end
      if (v_rd) nrd++;
      if (v_wr) begin nwr++; wd = v_wdata; wa = v_addr; end
      if (v_rd && v_wr) ovl++;
    end
  endtask

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem;
    logic [31:0] exp_wdata;
    logic        exp_err;
  } vec_t;

  vec_t vt [11];

  initial begin
    int lat, nd, nr, nw, ov, exp_lat;
    logic [31:0] wd, wa;
    logic ev;

    vt[0]  = '{2'b00, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,          32'hDEAD_BEEF, 1'b0};
    vt[1]  = '{2'b10, 32'h0000_0020, 32'h0000_00AA, 32'h1122_3344, 32'h1122_33AA, 1'b0};
    vt[2]  = '{2'b10, 32'h0000_0021, 32'h0000_00AA, 32'h1122_3344, 32'h1122_AA44, 1'b0};
    vt[3]  = '{2'b10, 32'h0000_0022, 32'h0000_00AA, 32'h1122_3344, 32'h11AA_3344, 1'b0};
    vt[4]  = '{2'b10, 32'h0000_0023, 32'h0000_00AA, 32'h1122_3344, 32'hAA22_3344, 1'b0};
    vt[5]  = '{2'b01, 32'h0000_0022, 32'h0000_BEEF, 32'h1122_3344, 32'hBEEF_3344, 1'b0};
    vt[6]  = '{2'b01, 32'h0000_0020, 32'h0000_BEEF, 32'h1122_3344, 32'h1122_BEEF, 1'b0};
    vt[7]  = '{2'b01, 32'h0000_0021, 32'h0000_BEEF, 32'h1122_3344, 32'h0,          1'b1};
    vt[8]  = '{2'b11, 32'h0000_0024, 32'h1234_5678, 32'h1122_3344, 32'h0,          1'b1};
    vt[9]  = '{2'b00, 32'h0000_0037, 32'h0102_0304, 32'hFFFF_FFFF, 32'h0102_0304, 1'b0};
    vt[10] = '{2'b10, 32'h0000_0023, 32'hFFFF_FF55, 32'h1122_3344, 32'h5522_3344, 1'b0};

    reset = 1'b1; st1 = 1'b0; st3 = 1'b0; size_i = '0; addr_i = '0; wdata_i = '0;
    mem_word = '0; sel_v = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_u1_addr_wdata", addr1 | wd1, 32'h0);
    chk("reset_u1_strobes", {27'd0, rd1, wr1, busy1, done1, err1}, 32'h0);
    chk("reset_u3_strobes", {27'd0, rd3, wr3, busy3, done3, err3}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      mem_word = vt[i].mem;
      run_store(1'b0, vt[i].size, vt[i].addr, vt[i].wdata, 1'b0, lat, nd, nr, nw, ov, wd, wa, ev);
      exp_lat = vt[i].exp_err ? 1 : (vt[i].size == 2'b00) ? 2 : 4;
      chk($sformatf("v%0d_latency", i), lat, exp_lat);
      chk($sformatf("v%0d_err", i), {31'd0, ev}, {31'd0, vt[i].exp_err});
      chk($sformatf("v%0d_done_count", i), nd, 1);
      chk($sformatf("v%0d_wr_count", i), nw, vt[i].exp_err ? 0 : 1);
      chk($sformatf("v%0d_rd_count", i), nr, (vt[i].exp_err || vt[i].size == 2'b00) ? 0 : 1);
      chk($sformatf("v%0d_rd_wr_overlap", i), ov, 0);
      if (!vt[i].exp_err) begin
        chk($sformatf("v%0d_mem_wdata", i), wd, vt[i].exp_wdata);
        chk($sformatf("v%0d_mem_addr", i), wa, {vt[i].addr[31:2], 2'b00});
      end
    end

    // MEM_LAT=3 byte store: done six cycles after the accepting edge.
    mem_word = 32'h1122_3344;
    run_store(1'b1, 2'b10, 32'h22, 32'h77, 1'b0, lat, nd, nr, nw, ov, wd, wa, ev);
    chk("lat3_latency", lat, 6);
    chk("lat3_mem_wdata", wd, 32'h1177_3344);
    chk("lat3_wr_count", nw, 1);
    chk("lat3_done_count", nd, 1);

    // start held high while busy, inputs scrambled after acceptance.
    run_store(1'b0, 2'b10, 32'h21, 32'hAA, 1'b1, lat, nd, nr, nw, ov, wd, wa, ev);
    chk("hold_wr_count", nw, 1);
    chk("hold_done_count", nd, 1);
    chk("hold_mem_wdata", wd, 32'h1122_AA44);
    chk("hold_mem_addr", wa, 32'h20);

    // start presented only during the DONE cycle is ignored.
    sel_v = 1'b0;
    @(negedge clk);
    size_i = 2'b00; addr_i = 32'h8; wdata_i = 32'hCAFE_F00D; st1 = 1'b1;
    @(posedge clk);
    @(negedge clk); st1 = 1'b0;
    @(negedge clk);
    chk("b2b_done_cycle", {31'd0, done1}, 32'd1);
    st1 = 1'b1;
    @(negedge clk); st1 = 1'b0;
    chk("b2b_ignored_busy", {31'd0, busy1}, 32'd0);
    @(negedge clk);
    chk("b2b_ignored_wr", {30'd0, wr1, busy1}, 32'd0);

    // Reset during WAIT on the MEM_LAT=3 instance aborts the store silently.
    mem_word = 32'h1122_3344;
    @(negedge clk);
    size_i = 2'b10; addr_i = 32'h20; wdata_i = 32'hAA; st3 = 1'b1;
    @(posedge clk);
    @(negedge clk); st3 = 1'b0;
    @(negedge clk);
    chk("rstwait_in_wait_busy", {31'd0, busy3}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rstwait_addr_wdata", addr3 | wd3, 32'h0);
    chk("rstwait_strobes", {27'd0, rd3, wr3, busy3, done3, err3}, 32'h0);
    nw = 0; nd = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (wr3) nw++;
      if (done3) nd++;
    end
    chk("rstwait_no_wr", nw, 0);
    chk("rstwait_no_done", nd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
